// File: rtl/apmu_ibex_wb_arbiter.sv
// Writeback arbiter for the register-file write port: merges ALU results with
// in-order load returns via a small ordered load queue and a pending-destination scoreboard.
module apmu_ibex_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned LsuDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_wb_valid_i,
  input  logic [4:0]           ex_wb_addr_i,
  input  logic [DataWidth-1:0] ex_wb_data_i,
  input  logic                 lsu_issue_i,
  input  logic [4:0]           lsu_issue_addr_i,
  output logic                 lsu_issue_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic [4:0]           id_raddr_a_i,
  input  logic [4:0]           id_raddr_b_i,
  input  logic [4:0]           id_waddr_i,
  output logic                 stall_o,
  output logic                 err_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o
);

  localparam int unsigned PtrW     = (LsuDepth > 1) ? $clog2(LsuDepth) : 1;
  localparam int unsigned CntW     = $clog2(LsuDepth + 1);
  localparam logic [4:0]  AddrMask = RV32E ? 5'h0F : 5'h1F;

  logic [4:0]           r_q_addr [LsuDepth];
  logic [DataWidth-1:0] r_q_data [LsuDepth];
  logic [LsuDepth-1:0]  r_q_valid;
  logic [LsuDepth-1:0]  r_q_dvalid;
  logic [PtrW-1:0]      r_head;
  logic [PtrW-1:0]      r_tail;
  logic [CntW-1:0]      r_count;

  logic            w_ready;
  logic            w_issue_ok;
  logic            w_issue_err;
  logic            w_fill_found;
  logic [PtrW-1:0] w_fill_idx;
  logic            w_fill;
  logic            w_ret_err;
  logic            w_head_dv;
  logic            w_bypass;
  logic            w_pop;
  logic [4:0]      w_ra;
  logic [4:0]      w_rb;
  logic [4:0]      w_rw;
  logic            w_stall;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(LsuDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  function automatic logic [PtrW-1:0] off2idx(input logic [PtrW-1:0] h, input int unsigned off);
    int unsigned s;
    s = 32'(h) + off;
    if (s >= LsuDepth) s = s - LsuDepth;
    return PtrW'(s);
  endfunction

  assign w_ready     = (r_count < CntW'(LsuDepth));
  assign w_issue_ok  = lsu_issue_i && w_ready;
  assign w_issue_err = lsu_issue_i && !w_ready;

  // Oldest entry still waiting for data; data-less entries form the tail of the queue.
  always_comb begin
    w_fill_found = 1'b0;
    w_fill_idx   = '0;
    for (int unsigned i = 0; i < LsuDepth; i++) begin
      if (!w_fill_found && (i < 32'(r_count)) && !r_q_dvalid[off2idx(r_head, i)]) begin
        w_fill_found = 1'b1;
        w_fill_idx   = off2idx(r_head, i);
      end
    end
  end

  assign w_fill    = lsu_rvalid_i && w_fill_found;
  assign w_ret_err = lsu_rvalid_i && !w_fill_found;
  assign w_head_dv = r_q_dvalid[r_head];
  assign w_bypass  = w_fill && (w_fill_idx == r_head);
  assign w_pop     = !ex_wb_valid_i && (r_count != '0) && (w_head_dv || w_bypass);

  assign lsu_issue_ready_o = w_ready;

  // Hazard check against every queued destination and the write in flight.
  always_comb begin
    w_ra    = id_raddr_a_i & AddrMask;
    w_rb    = id_raddr_b_i & AddrMask;
    w_rw    = id_waddr_i & AddrMask;
    w_stall = 1'b0;
    for (int unsigned k = 0; k < LsuDepth; k++) begin
      if (r_q_valid[k] && (((w_ra != 5'd0) && (r_q_addr[k] == w_ra)) ||
                           ((w_rb != 5'd0) && (r_q_addr[k] == w_rb)) ||
                           ((w_rw != 5'd0) && (r_q_addr[k] == w_rw)))) begin
        w_stall = 1'b1;
      end
    end
    if (rf_we_o && ((rf_waddr_o == w_ra) || (rf_waddr_o == w_rb) || (rf_waddr_o == w_rw))) begin
      w_stall = 1'b1;
    end
  end

  assign stall_o = w_stall;

  // Queue payload storage; contents are qualified by r_q_valid so need no reset.
  always_ff @(posedge clk_i) begin
    if (w_fill) r_q_data[w_fill_idx] <= lsu_rdata_i;
    if (w_issue_ok) r_q_addr[r_tail] <= lsu_issue_addr_i & AddrMask;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q_valid  <= '0;
      r_q_dvalid <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= 5'd0;
      rf_wdata_o <= '0;
      err_o      <= 1'b0;
    end else begin
      err_o <= w_issue_err || w_ret_err;

      if (ex_wb_valid_i) begin
        rf_waddr_o <= ex_wb_addr_i & AddrMask;
        rf_wdata_o <= ex_wb_data_i;
        rf_we_o    <= ((ex_wb_addr_i & AddrMask) != 5'd0);
      end else if (w_pop) begin
        rf_waddr_o <= r_q_addr[r_head];
        rf_wdata_o <= w_head_dv ? r_q_data[r_head] : lsu_rdata_i;
        rf_we_o    <= (r_q_addr[r_head] != 5'd0);
      end else begin
        rf_we_o <= 1'b0;
      end

      // Fill before pop so a bypassed head is cleared in the same cycle.
      if (w_fill) r_q_dvalid[w_fill_idx] <= 1'b1;
      if (w_pop) begin
        r_q_valid[r_head]  <= 1'b0;
        r_q_dvalid[r_head] <= 1'b0;
        r_head             <= ptr_inc(r_head);
      end
      if (w_issue_ok) begin
        r_q_valid[r_tail]  <= 1'b1;
        r_q_dvalid[r_tail] <= 1'b0;
        r_tail             <= ptr_inc(r_tail);
      end
      r_count <= r_count + CntW'(w_issue_ok) - CntW'(w_pop);
    end
  end

endmodule

// File: tb/tb_apmu_ibex_wb_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, compared against
// a queue-based behavioural model of the writeback arbiter.
module tb_apmu_ibex_wb_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ex_wb_valid_i;
  logic [4:0]    ex_wb_addr_i;
  logic [DW-1:0] ex_wb_data_i;
  logic          lsu_issue_i;
  logic [4:0]    lsu_issue_addr_i;
  logic          lsu_issue_ready_o;
  logic          lsu_rvalid_i;
  logic [DW-1:0] lsu_rdata_i;
  logic [4:0]    id_raddr_a_i;
  logic [4:0]    id_raddr_b_i;
  logic [4:0]    id_waddr_i;
  logic          stall_o;
  logic          err_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_we_o;

  apmu_ibex_wb_arbiter #(.DataWidth(DW), .RV32E(1'b0), .LsuDepth(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_wb_valid_i(ex_wb_valid_i), .ex_wb_addr_i(ex_wb_addr_i), .ex_wb_data_i(ex_wb_data_i),
    .lsu_issue_i(lsu_issue_i), .lsu_issue_addr_i(lsu_issue_addr_i),
    .lsu_issue_ready_o(lsu_issue_ready_o),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
    .id_raddr_a_i(id_raddr_a_i), .id_raddr_b_i(id_raddr_b_i), .id_waddr_i(id_waddr_i),
    .stall_o(stall_o), .err_o(err_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
    bit            dv;
  } ent_t;

  ent_t          mq[$];
  bit            m_we;
  bit            m_err;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_pending(input logic [4:0] x);
    if (x == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == x) return 1'b1;
    return m_we && (m_waddr == x);
  endfunction

  function automatic bit in_queue(input logic [4:0] x);
    foreach (mq[i]) if (mq[i].a == x) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    ex_wb_valid_i    = 1'b0;
    ex_wb_addr_i     = 5'd0;
    ex_wb_data_i     = '0;
    lsu_issue_i      = 1'b0;
    lsu_issue_addr_i = 5'd0;
    lsu_rvalid_i     = 1'b0;
    lsu_rdata_i      = '0;
    id_raddr_a_i     = 5'd0;
    id_raddr_b_i     = 5'd0;
    id_waddr_i       = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    id_raddr_a_i = 5'd12;
    id_raddr_b_i = 5'd13;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mq.delete();
    m_we = 1'b0; m_err = 1'b0; m_waddr = 5'd0; m_wdata = '0;
    #1;
    chk("rst_we", 64'(rf_we_o), 64'd0);
    chk("rst_waddr", 64'(rf_waddr_o), 64'd0);
    chk("rst_wdata", 64'(rf_wdata_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ready", 64'(lsu_issue_ready_o), 64'd1);
    chk("rst_stall", 64'(stall_o), 64'd0);
  endtask

  // One clock cycle: drive, check combinational outputs, advance model and DUT, check registers.
  task automatic cyc(input bit av, input logic [4:0] aa, input logic [DW-1:0] ad,
                     input bit iss, input logic [4:0] ia,
                     input bit rv, input logic [DW-1:0] rd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw);
    bit rdy;
    bit e;
    int fi;
    ex_wb_valid_i = av; ex_wb_addr_i = aa; ex_wb_data_i = ad;
    lsu_issue_i = iss; lsu_issue_addr_i = ia;
    lsu_rvalid_i = rv; lsu_rdata_i = rd;
    id_raddr_a_i = ra; id_raddr_b_i = rb; id_waddr_i = rw;
    #1;
    rdy = (mq.size() < DEPTH);
    chk("ready", 64'(lsu_issue_ready_o), 64'(rdy));
    chk("stall", 64'(stall_o), 64'(m_pending(ra) || m_pending(rb) || m_pending(rw)));

    e  = 1'b0;
    fi = -1;
    foreach (mq[i]) if (fi < 0 && !mq[i].dv) fi = i;
    if (rv) begin
      if (fi < 0) e = 1'b1;
      else begin mq[fi].dv = 1'b1; mq[fi].d = rd; end
    end
    if (iss && !rdy) e = 1'b1;
    if (av) begin
      m_we = (aa != 5'd0); m_waddr = aa; m_wdata = ad;
    end else if (mq.size() > 0 && mq[0].dv) begin
      m_we = (mq[0].a != 5'd0); m_waddr = mq[0].a; m_wdata = mq[0].d;
      void'(mq.pop_front());
    end else begin
      m_we = 1'b0;
    end
    if (iss && rdy) mq.push_back('{a: ia, d: '0, dv: 1'b0});
    m_err = e;

    @(posedge clk_i); #1;
    chk("we", 64'(rf_we_o), 64'(m_we));
    chk("err", 64'(err_o), 64'(m_err));
    if (m_we) begin
      chk("waddr", 64'(rf_waddr_o), 64'(m_waddr));
      chk("wdata", 64'(rf_wdata_o), 64'(m_wdata));
    end
  endtask

  task automatic idle(input logic [4:0] ra);
    cyc(0, 5'd0, '0, 0, 5'd0, 0, '0, ra, 5'd0, 5'd0);
  endtask

  initial begin
    rst_i = 1'b0;
    idle_inputs();
    @(posedge clk_i); #1;
    do_reset();

    // ALU only
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, '0, 5'd5, 5'd0, 5'd0);
    chk("alu_we", 64'(rf_we_o), 64'd1);
    chk("alu_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);
    idle(5'd5);
    idle(5'd5);

    // Load bypass
    cyc(0, 5'd0, '0, 1, 5'd7, 0, '0, 5'd7, 5'd0, 5'd0);
    idle(5'd7);
    cyc(0, 5'd0, '0, 0, 5'd0, 1, 32'h12345678, 5'd7, 5'd0, 5'd0);
    chk("byp_waddr", 64'(rf_waddr_o), 64'd7);
    chk("byp_wdata", 64'(rf_wdata_o), 64'h12345678);
    idle(5'd7);
    idle(5'd7);

    // Collision: ALU wins, load follows
    cyc(0, 5'd0, '0, 1, 5'd10, 0, '0, 5'd10, 5'd3, 5'd0);
    cyc(1, 5'd3, 32'h0000A5A5, 0, 5'd0, 1, 32'hCAFEF00D, 5'd10, 5'd3, 5'd0);
    chk("col_alu_addr", 64'(rf_waddr_o), 64'd3);
    idle(5'd10);
    idle(5'd10);
    chk("col_ld_addr", 64'(rf_waddr_o), 64'd10);
    idle(5'd10);

    // Fill, overflow, in-order returns
    cyc(0, 5'd0, '0, 1, 5'd8, 0, '0, 5'd8, 5'd9, 5'd0);
    cyc(0, 5'd0, '0, 1, 5'd9, 0, '0, 5'd8, 5'd9, 5'd0);
    cyc(0, 5'd0, '0, 1, 5'd11, 0, '0, 5'd11, 5'd9, 5'd0);
    chk("ovf_err", 64'(err_o), 64'd1);
    cyc(0, 5'd0, '0, 0, 5'd0, 1, 32'h88888888, 5'd8, 5'd9, 5'd0);
    cyc(0, 5'd0, '0, 0, 5'd0, 1, 32'h99999999, 5'd8, 5'd9, 5'd0);
    idle(5'd9);
    idle(5'd9);

    // Register 0 load and empty-queue return
    cyc(0, 5'd0, '0, 1, 5'd0, 0, '0, 5'd0, 5'd0, 5'd0);
    cyc(0, 5'd0, '0, 0, 5'd0, 1, 32'h00000BAD, 5'd0, 5'd0, 5'd0);
    chk("x0_we", 64'(rf_we_o), 64'd0);
    cyc(0, 5'd0, '0, 0, 5'd0, 1, 32'h0000DEAD, 5'd0, 5'd0, 5'd0);
    chk("empty_err", 64'(err_o), 64'd1);
    idle(5'd0);

    // Reset with loads outstanding, then a late return
    cyc(0, 5'd0, '0, 1, 5'd12, 0, '0, 5'd12, 5'd0, 5'd0);
    cyc(0, 5'd0, '0, 1, 5'd13, 0, '0, 5'd12, 5'd13, 5'd0);
    do_reset();
    cyc(0, 5'd0, '0, 0, 5'd0, 1, 32'h1A7E1A7E, 5'd12, 5'd13, 5'd0);
    chk("late_err", 64'(err_o), 64'd1);
    idle(5'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit            av, iss, rv;
      logic [4:0]    aa, ia;
      logic [DW-1:0] ad, rd;
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        av  = ($urandom_range(0, 2) == 0);
        aa  = 5'($urandom_range(0, 31));
        for (int t = 0; t < 8 && in_queue(aa); t++) aa = 5'($urandom_range(0, 31));
        if (in_queue(aa)) av = 1'b0;
        ad  = $urandom;
        iss = ($urandom_range(0, 1) == 0);
        ia  = 5'($urandom_range(0, 31));
        rv  = ($urandom_range(0, 2) == 0);
        rd  = $urandom;
        cyc(av, aa, ad, iss, ia, rv, rd,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
